multiplicador_algoritmico: RTL and testbench

MULTIPLICADOR_ALGORITMICO -- requirements
Module: multiplicador_algoritmico

---
 rtl/aritmetica_pkg.sv | 17 +
 rtl/complemento_a2.sv | 18 +
 rtl/multiplicador_algoritmico.sv | 124 ++++++++++++
 tb/tb_multiplicador_algoritmico.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/aritmetica_pkg.sv
// aritmetica_pkg
// Shared definitions for the algorithmic arithmetic blocks (multiplier and
// divider). Holds the default operand width and the control state encoding
// so that both blocks agree on it.
package aritmetica_pkg;

  // Default operand/result width for the arithmetic blocks
  localparam int TAMANYO_DEF = 32;

  // Sequencer states shared by the multiplier and the divider
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } estado_t;

endpackage

// File: rtl/complemento_a2.sv
// complemento_a2
// Conditional two's-complement negation.
//   a   : input word, ancho bits
//   neg : when 1 the output is -a, otherwise a passes through
//   y   : result, ancho bits
// Negating the most negative value wraps to itself, which is exactly the
// unsigned magnitude 2^(ancho-1) needed when extracting operand magnitudes.
module complemento_a2 #(
  parameter int ancho = 32
) (
  input  logic [ancho-1:0] a,
  input  logic             neg,
  output logic [ancho-1:0] y
);

  assign y = neg ? (~a + {{(ancho-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/multiplicador_algoritmico.sv
// multiplicador_algoritmico
// Sequential shift-add multiplier computing num = coc*den + res, the inverse
// of the algorithmic divider, with the same start/done handshake.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request, sampled only while idle
//   coc   : signed multiplicand (quotient)
//   den   : signed multiplier (divisor)
//   res   : signed addend (remainder)
//   num   : low tamanyo bits of coc*den+res, registered
//   ovf   : full result does not fit in tamanyo signed bits, registered
//   done  : one-cycle completion pulse, tamanyo+1 edges after start is taken
import aritmetica_pkg::*;

module multiplicador_algoritmico #(
  parameter int tamanyo = TAMANYO_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [tamanyo-1:0] coc,
  input  logic [tamanyo-1:0] den,
  input  logic [tamanyo-1:0] res,
  output logic [tamanyo-1:0] num,
  output logic               ovf,
  output logic               done
);

  localparam int CW = $clog2(tamanyo + 1);

  estado_t              estado;
  logic [2*tamanyo-1:0] multiplicando;
  logic [2*tamanyo-1:0] acumulador;
  logic [tamanyo-1:0]   multiplicador;
  logic [tamanyo-1:0]   resto;
  logic                 signo;
  logic [CW-1:0]        contador;

  logic [tamanyo-1:0]   mag_coc;
  logic [tamanyo-1:0]   mag_den;
  logic [2*tamanyo-1:0] acc_fix;
  logic [2*tamanyo:0]   suma;
  logic                 desborde;

  // Unsigned magnitudes of the operands, taken straight from the inputs
  complemento_a2 #(.ancho(tamanyo)) u_mag_coc (
    .a   (coc),
    .neg (coc[tamanyo-1]),
    .y   (mag_coc)
  );

  complemento_a2 #(.ancho(tamanyo)) u_mag_den (
    .a   (den),
    .neg (den[tamanyo-1]),
    .y   (mag_den)
  );

  // Restore the product sign on the unsigned accumulator
  complemento_a2 #(.ancho(2*tamanyo)) u_signo (
    .a   (acumulador),
    .neg (signo),
    .y   (acc_fix)
  );

  // One extra bit so that the signed product plus the addend never wraps
  assign suma = {acc_fix[2*tamanyo-1], acc_fix}
              + {{(tamanyo+1){resto[tamanyo-1]}}, resto};

  // Representable only if every bit from the result msb upward is a copy
  // of the sign
  assign desborde = ~((&suma[2*tamanyo:tamanyo-1]) | ~(|suma[2*tamanyo:tamanyo-1]));

  // Control and datapath: capture in IDLE, tamanyo shift-add steps in MUL,
  // sign fix / addend / result registration in FIX. The step count never
  // depends on the data, so latency is fixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado        <= IDLE;
      multiplicando <= '0;
      acumulador    <= '0;
      multiplicador <= '0;
      resto         <= '0;
      signo         <= 1'b0;
      contador      <= '0;
      num           <= '0;
      ovf           <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (estado)
        IDLE: begin
          if (start) begin
            multiplicando <= {{tamanyo{1'b0}}, mag_coc};
            multiplicador <= mag_den;
            signo         <= coc[tamanyo-1] ^ den[tamanyo-1];
            resto         <= res;
            acumulador    <= '0;
            contador      <= CW'(tamanyo);
            estado        <= MUL;
          end
        end
        MUL: begin
          if (multiplicador[0]) begin
            acumulador <= acumulador + multiplicando;
          end
          multiplicando <= multiplicando << 1;
          multiplicador <= multiplicador >> 1;
          contador      <= contador - CW'(1);
          if (contador == CW'(1)) begin
            estado <= FIX;
          end
        end
        FIX: begin
          num    <= suma[tamanyo-1:0];
          ovf    <= desborde;
          done   <= 1'b1;
          estado <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// tb_multiplicador_algoritmico
// Self-checking bench for multiplicador_algoritmico at tamanyo=32.
// Expected results come from a plain-arithmetic model: coc*den+res in 64-bit
// signed integers, with overflow judged against the 32-bit signed range.
module tb_multiplicador_algoritmico;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] coc;
  logic [W-1:0] den;
  logic [W-1:0] res;
  logic [W-1:0] num;
  logic         ovf;
  logic         done;

  int vectors = 0;
  int misses  = 0;

  multiplicador_algoritmico #(.tamanyo(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .coc   (coc),
    .den   (den),
    .res   (res),
    .num   (num),
    .ovf   (ovf),
    .done  (done)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Safety net in case something stalls beyond every bounded wait
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts the vector and reports any miscompare
  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      misses++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: exact signed product plus addend, then truncate and range-check
  function automatic void refModel(input logic [W-1:0] c, input logic [W-1:0] d,
                                   input logic [W-1:0] r,
                                   output logic [W-1:0] n, output logic o);
    longint full;
    longint lim;
    full = longint'($signed(c)) * longint'($signed(d)) + longint'($signed(r));
    lim  = longint'(1) <<< (W - 1);
    n    = full[W-1:0];
    o    = (full < -lim) || (full > lim - 1);
  endfunction

  // Present operands with start on a falling edge, let the rising edge take
  // them, then (unless held) drop start and scramble the operand inputs so a
  // design that re-reads them mid-operation gets caught
  task automatic applyStimulus(input logic [W-1:0] c, input logic [W-1:0] d,
                               input logic [W-1:0] r, input bit hold);
    @(negedge clk);
    coc   = c;
    den   = d;
    res   = r;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      start = 1'b0;
      coc   = $urandom;
      den   = $urandom;
      res   = $urandom;
    end
  endtask

  // Wait (bounded) for done, checking edge count since sampling, result and
  // overflow; optionally raise/drop start at given edges and then verify done
  // stays low for 'tail' further cycles
  task automatic checkOutput(input string tag, input logic [W-1:0] c,
                             input logic [W-1:0] d, input logic [W-1:0] r,
                             input int expEdges, input int pokeAt,
                             input int dropAt, input int tail);
    logic [W-1:0] expNum;
    logic         expOvf;
    int           edges;
    int           extra;
    refModel(c, d, r, expNum, expOvf);
    edges = 0;
    while (edges < 80) begin
      @(posedge clk);
      #1;
      edges++;
      if (done === 1'b1) break;
      if (edges == pokeAt) begin
        @(negedge clk);
        start = 1'b1;
      end else if (edges == dropAt) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    compare({tag, " latency"}, 64'(edges), 64'(expEdges));
    compare({tag, " num"}, 64'(num), 64'(expNum));
    compare({tag, " ovf"}, 64'(ovf), 64'(expOvf));
    if (tail > 0) begin
      extra = 0;
      repeat (tail) begin
        @(posedge clk);
        #1;
        if (done !== 1'b0) extra++;
      end
      compare({tag, " extra done"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    int seen;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] r;

    rst_n = 1'b0;
    start = 1'b0;
    coc   = '0;
    den   = '0;
    res   = '0;

    // Reset state, before and after a clock edge with reset held
    #3;
    compare("reset num", 64'(num), 64'd0);
    compare("reset ovf", 64'(ovf), 64'd0);
    compare("reset done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    compare("reset held done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed cases");
    applyStimulus(32'd2, 32'd2, 32'd0, 1'b0);
    checkOutput("2*2", 32'd2, 32'd2, 32'd0, 33, -1, -1, 1);
    applyStimulus(-32'sd2, 32'd2, 32'd0, 1'b0);
    checkOutput("-2*2", -32'sd2, 32'd2, 32'd0, 33, -1, -1, 1);
    applyStimulus(32'd2, -32'sd2, 32'd0, 1'b0);
    checkOutput("2*-2", 32'd2, -32'sd2, 32'd0, 33, -1, -1, 1);
    applyStimulus(-32'sd2, -32'sd2, 32'd0, 1'b0);
    checkOutput("-2*-2", -32'sd2, -32'sd2, 32'd0, 33, -1, -1, 1);
    applyStimulus(-32'sd7, 32'd3, -32'sd1, 1'b0);
    checkOutput("-7*3-1", -32'sd7, 32'd3, -32'sd1, 33, -1, -1, 1);
    applyStimulus(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
    checkOutput("2^16*2^16", 32'h0001_0000, 32'h0001_0000, 32'd0, 33, -1, -1, 1);
    applyStimulus(32'h8000_0000, 32'd1, 32'd0, 1'b0);
    checkOutput("min*1", 32'h8000_0000, 32'd1, 32'd0, 33, -1, -1, 1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
    checkOutput("min*min+min", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 33, -1, -1, 1);
    applyStimulus(32'h1234_5678, 32'd0, -32'sd9, 1'b0);
    checkOutput("x*0-9", 32'h1234_5678, 32'd0, -32'sd9, 33, -1, -1, 1);

    $display("[TB] reset during MUL");
    applyStimulus(32'd9, 32'd9, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compare("abort num", 64'(num), 64'd0);
    compare("abort ovf", 64'(ovf), 64'd0);
    compare("abort done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) seen++;
    end
    compare("abort no done", 64'(seen), 64'd0);
    applyStimulus(32'd5, 32'd5, 32'd3, 1'b0);
    checkOutput("after abort", 32'd5, 32'd5, 32'd3, 33, -1, -1, 1);

    $display("[TB] start ignored while busy");
    applyStimulus(32'd11, -32'sd13, 32'd100, 1'b0);
    checkOutput("ignored start", 32'd11, -32'sd13, 32'd100, 33, 5, 6, 40);

    $display("[TB] start held through done");
    applyStimulus(32'd6, 32'd7, 32'd1, 1'b1);
    coc = -32'sd3;
    den = 32'd1000;
    res = 32'd4;
    checkOutput("held first", 32'd6, 32'd7, 32'd1, 33, -1, -1, 0);
    checkOutput("held second", -32'sd3, 32'd1000, 32'd4, 34, -1, 1, 1);

    $display("[TB] random triples");
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          c = $urandom;
          d = $urandom;
          r = $urandom;
        end
        1: begin
          c = W'(int'($urandom_range(0, 255)) - 128);
          d = W'(int'($urandom_range(0, 255)) - 128);
          r = W'(int'($urandom_range(0, 255)) - 128);
        end
        2: begin
          c = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          d = W'(int'($urandom_range(0, 4)) - 2);
          r = $urandom;
        end
        default: begin
          c = $urandom;
          d = 32'd0;
          r = $urandom;
        end
      endcase
      applyStimulus(c, d, r, 1'b0);
      checkOutput("random", c, d, r, 33, -1, -1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
